// File: rtl/rotate_cmd_sequencer.sv
// Command sequencer for the 8-bit barrel rotator: accepts rotate requests, steps the
// rotator through load/rotate/hold, captures its output and returns it over valid/ready.
module rotate_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int SW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [SW-1:0]    req_amt,
    input  logic             req_dir,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       rot_c,
    output logic [SW-1:0]    rot_s,
    output logic [WIDTH-1:0] rot_i,
    input  logic [WIDTH-1:0] rot_o,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] ROT_HOLD  = 2'b00;
    localparam logic [1:0] ROT_LEFT  = 2'b01;
    localparam logic [1:0] ROT_RIGHT = 2'b10;
    localparam logic [1:0] ROT_LOAD  = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, ROT, CAP, RESP} state_t;

    state_t        state;
    logic [SW-1:0] amt_q;
    logic          dir_q;

    // Gated by rst so a request presented during reset is never seen as accepted.
    assign req_ready = (state == IDLE) && !rst;

    // NOTE: every register here uses <= so all updates see pre-edge values, matching hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            amt_q     <= '0;
            dir_q     <= 1'b0;
            rot_c     <= ROT_HOLD;
            rot_s     <= '0;
            rot_i     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rot_i <= req_data;
                        amt_q <= req_amt;
                        dir_q <= req_dir;
                        rot_c <= ROT_LOAD;
                        rot_s <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // A zero amount skips the rotate step; the loaded word is the result.
                    if (amt_q != '0) begin
                        rot_c <= dir_q ? ROT_RIGHT : ROT_LEFT;
                        rot_s <= amt_q;
                        state <= ROT;
                    end else begin
                        rot_c <= ROT_HOLD;
                        state <= CAP;
                    end
                end
                ROT: begin
                    rot_c <= ROT_HOLD;
                    rot_s <= '0;
                    state <= CAP;
                end
                CAP: begin
                    res_data  <= rot_o;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    rot_c <= ROT_HOLD;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Bench for rotate_cmd_sequencer: models the downstream rotator register, runs table
// vectors, reset/backpressure/back-to-back sequences and random ops against a reference.
module tb_rotate_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_data;
    logic [2:0]  req_amt;
    logic        req_dir;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  rot_c;
    logic [2:0]  rot_s;
    logic [7:0]  rot_i;
    logic [7:0]  rot_o;
    logic [15:0] done_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_done = 0;

    rotate_cmd_sequencer #(.WIDTH(8), .SW(3), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_amt  (req_amt),
        .req_dir  (req_dir),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .rot_c    (rot_c),
        .rot_s    (rot_s),
        .rot_i    (rot_i),
        .rot_o    (rot_o),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    // Rotator register: rotates one bit position at a time, n times.
    function automatic logic [7:0] step_rotate(input logic [7:0] v, input logic [2:0] n, input logic right);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < int'(n); i++)
            r = right ? {r[0], r[7:1]} : {r[6:0], r[7]};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) rot_o <= 8'h00;
        else case (rot_c)
            2'b11:   rot_o <= rot_i;
            2'b01:   rot_o <= step_rotate(rot_o, rot_s, 1'b0);
            2'b10:   rot_o <= step_rotate(rot_o, rot_s, 1'b1);
            default: rot_o <= rot_o;
        endcase
    end

    // Reference result: rotation as a window into the doubled word.
    function automatic logic [7:0] ref_rotate(input logic [7:0] d, input logic [2:0] n, input logic right);
        logic [15:0] w;
        w = {d, d};
        if (right) begin
            w = w >> n;
            return w[7:0];
        end
        w = w << n;
        return w[15:8];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE through the result handshake; returns result and latency.
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic dir,
                          input int stall, input bit hold_ready,
                          output logic [7:0] res, output int lat);
        logic [1:0] exp_c;
        logic [7:0] held;
        int k;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_dir   = dir;
        if (!hold_ready) res_ready = 1'b0;
        tick();
        // Scramble request inputs after accept; the op in flight must not notice.
        req_valid = 1'b0;
        req_data  = ~d;
        req_amt   = a + 3'd3;
        req_dir   = ~dir;
        lat = 0;
        k   = 0;
        res = 8'h00;
        while (!res_valid && lat < 10) begin
            if (k == 0) exp_c = 2'b11;
            else if (k == 1 && a != 3'd0) exp_c = dir ? 2'b10 : 2'b01;
            else exp_c = 2'b00;
            check("rot_c_seq", 32'(rot_c), 32'(exp_c));
            check("req_ready_busy", 32'(req_ready), 32'd0);
            tick();
            lat++;
            k++;
        end
        if (!res_valid) begin
            check("res_timeout", 32'(res_valid), 32'd1);
            return;
        end
        res  = res_data;
        held = res_data;
        check("rot_c_resp", 32'(rot_c), 32'd0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            req_data  = 8'($urandom);
            tick();
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", 32'(res_data), 32'(held));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        if (!hold_ready) res_ready = 1'b0;
        exp_done++;
        check("done_cnt", 32'(done_cnt), 32'(exp_done[15:0]));
        check("idle_after_hs", {30'd0, req_ready, res_valid}, 32'b10);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       dir;
        logic [7:0] exp_res;
        int         exp_lat;
        int         stall;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] res;
        int         lat;
        logic [7:0] rd;
        logic [2:0] ra;
        logic       rdir;

        vecs[0] = '{d: 8'h81, a: 3'd1, dir: 1'b0, exp_res: 8'h03, exp_lat: 3, stall: 0};
        vecs[1] = '{d: 8'h81, a: 3'd1, dir: 1'b1, exp_res: 8'hC0, exp_lat: 3, stall: 0};
        vecs[2] = '{d: 8'hA5, a: 3'd4, dir: 1'b0, exp_res: 8'h5A, exp_lat: 3, stall: 0};
        vecs[3] = '{d: 8'h3C, a: 3'd0, dir: 1'b0, exp_res: 8'h3C, exp_lat: 2, stall: 0};
        vecs[4] = '{d: 8'h96, a: 3'd5, dir: 1'b1, exp_res: 8'hB4, exp_lat: 3, stall: 5};

        // Reset with a request present: reset wins.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_data  = 8'hFF;
        req_amt   = 3'd2;
        req_dir   = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rot_c", 32'(rot_c), 32'd0);
        check("rst_rot_s_i", {21'd0, rot_s, rot_i}, 32'd0);
        check("rst_res", {23'd0, res_valid, res_data}, 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        req_valid = 1'b0;
        res_ready = 1'b0;
        rst       = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        tick();
        check("idle_hold_rot_c", 32'(rot_c), 32'd0);

        // Reset while in ROT aborts the op with no result.
        req_valid = 1'b1;
        req_data  = 8'h5A;
        req_amt   = 3'd3;
        req_dir   = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("midop_in_rot", 32'(rot_c), 32'b01);
        rst = 1'b1;
        tick();
        check("midop_rot_c", 32'(rot_c), 32'd0);
        check("midop_res_valid", 32'(res_valid), 32'd0);
        check("midop_done_cnt", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("midop_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midop_no_result", {30'd0, res_valid, rot_c != 2'b00}, 32'd0);
        end

        // Directed vectors, including a backpressure stall.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].stall, 1'b0, res, lat);
            check($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Back-to-back with res_ready held high: 0x01 rotated left by 0..7.
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(8'h01, 3'(i), 1'b0, 0, 1'b1, res, lat);
            check($sformatf("b2b%0d_res", i), 32'(res), 32'(8'h01 << i));
        end
        res_ready = 1'b0;
        check("b2b_done_cnt", 32'(done_cnt), 32'd13);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rd   = 8'($urandom);
            ra   = 3'($urandom);
            rdir = 1'($urandom);
            run_op(rd, ra, rdir, int'($urandom_range(0, 3)), 1'b0, res, lat);
            check("rand_res", 32'(res), 32'(ref_rotate(rd, ra, rdir)));
            check("rand_lat", lat, (ra != 3'd0) ? 3 : 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
